// File: rtl/axi4_lite_master_pkg.sv
// Shared widths and FSM state encodings for the AXI4-Lite master.
package axi4_lite_Defs;

  localparam int unsigned Addr_Width = 32;
  localparam int unsigned Data_Width = 32;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2,
    W_DONE = 2'd3
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2,
    R_DONE = 2'd3
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: turns single-cycle read/write strobes into full AXI4-Lite
// transactions. Independent registered write and read engines.
module axi4_lite_master #(
  parameter int unsigned Addr_Width = axi4_lite_Defs::Addr_Width,
  parameter int unsigned Data_Width = axi4_lite_Defs::Data_Width
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  wr_start,
  input  logic [Addr_Width-1:0] wr_addr,
  input  logic [Data_Width-1:0] wr_data,
  output logic                  wr_busy,
  output logic                  wr_done,
  input  logic                  rd_start,
  input  logic [Addr_Width-1:0] rd_addr,
  output logic [Data_Width-1:0] rd_data,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic [Addr_Width-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [Data_Width-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [Addr_Width-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [Data_Width-1:0] RDATA,
  input  logic                  RVALID,
  output logic                  RREADY
);

  import axi4_lite_Defs::*;

  wr_state_t             wr_state_q, wr_state_d;
  logic [Addr_Width-1:0] awaddr_q, awaddr_d;
  logic [Data_Width-1:0] wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  wr_done_q, wr_done_d;

  rd_state_t             rd_state_q, rd_state_d;
  logic [Addr_Width-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [Data_Width-1:0] rd_data_q, rd_data_d;
  logic                  rd_done_q, rd_done_d;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= W_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      wr_done_q  <= wr_done_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    wr_done_d  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_start) begin
          awaddr_d   = wr_addr;
          wdata_d    = wr_data;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        // AW and W handshakes retire independently; response phase starts
        // once neither valid remains outstanding.
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d   = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BVALID) begin
          bready_d   = 1'b0;
          wr_done_d  = 1'b1;
          wr_state_d = W_DONE;
        end
      end
      W_DONE:  wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= R_IDLE;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_done_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      rd_data_q  <= rd_data_d;
      rd_done_q  <= rd_done_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    rd_data_d  = rd_data_q;
    rd_done_d  = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_start) begin
          araddr_d   = rd_addr;
          arvalid_d  = 1'b1;
          rready_d   = 1'b1;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (ARREADY) begin
          arvalid_d  = 1'b0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RVALID) begin
          rd_data_d  = RDATA;
          rready_d   = 1'b0;
          rd_done_d  = 1'b1;
          rd_state_d = R_DONE;
        end
      end
      R_DONE:  rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign AWADDR  = awaddr_q;
  assign AWVALID = awvalid_q;
  assign WDATA   = wdata_q;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;
  assign wr_done = wr_done_q;
  assign wr_busy = (wr_state_q != W_IDLE);

  assign ARADDR  = araddr_q;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;
  assign rd_data = rd_data_q;
  assign rd_done = rd_done_q;
  assign rd_busy = (rd_state_q != R_IDLE);

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master against a small AXI4-Lite slave model
// with programmable ready delays.
module tb_axi4_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        wr_start, rd_start;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic        wr_busy, wr_done, rd_busy, rd_done;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;

  int unsigned aw_delay, w_delay, ar_delay;
  int unsigned aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got, clr_mem;
  logic [31:0] aw_addr_l, w_data_l;
  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_busy(wr_busy), .wr_done(wr_done),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .rd_done(rd_done),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Ready rises once the matching valid has been seen for <delay> edges.
  assign AWREADY = (aw_cnt >= aw_delay);
  assign WREADY  = (w_cnt >= w_delay);
  assign ARREADY = (ar_cnt >= ar_delay);

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      aw_addr_l <= '0; w_data_l <= '0;
      BVALID <= 1'b0; RVALID <= 1'b0; RDATA <= '0;
      if (clr_mem) for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      if (BVALID && BREADY) BVALID <= 1'b0;
      else if (aw_got && w_got && !BVALID) begin
        BVALID <= 1'b1;
        mem[aw_addr_l[7:2]] <= w_data_l;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (AWVALID && AWREADY) begin
        aw_cnt <= 0; aw_got <= 1'b1; aw_addr_l <= AWADDR;
      end else if (AWVALID) aw_cnt <= aw_cnt + 1;
      if (WVALID && WREADY) begin
        w_cnt <= 0; w_got <= 1'b1; w_data_l <= WDATA;
      end else if (WVALID) w_cnt <= w_cnt + 1;
      if (RVALID && RREADY) RVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        ar_cnt <= 0; RVALID <= 1'b1; RDATA <= mem[ARADDR[7:2]];
      end else if (ARVALID) ar_cnt <= ar_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int wd, rdn, av;
    logic [31:0] cap;

    ARESETN = 1'b0; clr_mem = 1'b1;
    wr_start = 1'b0; wr_addr = '0; wr_data = '0;
    rd_start = 1'b0; rd_addr = '0;
    aw_delay = 0; w_delay = 0; ar_delay = 0;

    #12;
    chk("reset_ctl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, wr_busy, rd_busy, wr_done, rd_done}, 32'h0);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_awaddr", AWADDR, 32'h0);
    @(negedge ACLK); ARESETN = 1'b1; clr_mem = 1'b0;

    // Write, zero-wait slave
    @(negedge ACLK); wr_start = 1'b1; wr_addr = 32'h010; wr_data = 32'hDEADBEEF;
    @(posedge ACLK); #1; wr_start = 1'b0;
    chk("w1_valids", {AWVALID, WVALID}, 32'h3);
    chk("w1_awaddr", AWADDR, 32'h010);
    chk("w1_wdata", WDATA, 32'hDEADBEEF);
    chk("w1_busy_bready", {wr_busy, BREADY}, 32'h2);
    @(posedge ACLK); #1;
    chk("w1_hs_done", {AWVALID, WVALID, BREADY}, 32'h1);
    @(posedge ACLK); #1;
    chk("w1_wait_b", {BREADY, wr_done}, 32'h2);
    @(posedge ACLK); #1;
    chk("w1_done", {BREADY, wr_done, wr_busy}, 32'h3);
    @(posedge ACLK); #1;
    chk("w1_idle", {wr_done, wr_busy}, 32'h0);
    chk("w1_mem", mem[4], 32'hDEADBEEF);

    // Read-back
    @(negedge ACLK); rd_start = 1'b1; rd_addr = 32'h010;
    @(posedge ACLK); #1; rd_start = 1'b0;
    chk("r1_ar_rr", {ARVALID, RREADY, rd_busy}, 32'h7);
    chk("r1_araddr", ARADDR, 32'h010);
    @(posedge ACLK); #1;
    chk("r1_rdata_phase", {ARVALID, RREADY, rd_done}, 32'h2);
    @(posedge ACLK); #1;
    chk("r1_done", {rd_done, RREADY}, 32'h2);
    chk("r1_data", rd_data, 32'hDEADBEEF);
    @(posedge ACLK); #1;
    chk("r1_idle", {rd_done, rd_busy}, 32'h0);

    // Stalled responder
    @(negedge ACLK);
    aw_delay = 3; w_delay = 5;
    wr_start = 1'b1; wr_addr = 32'h040; wr_data = 32'hA5A50F0F;
    @(posedge ACLK); #1; wr_start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge ACLK); #1;
      chk($sformatf("stall_aw_%0d", i), AWVALID, (i < 4));
      chk($sformatf("stall_w_%0d", i), WVALID, (i < 6));
      chk($sformatf("stall_b_%0d", i), BREADY, (i >= 6));
      chk($sformatf("stall_addr_%0d", i), AWADDR, 32'h040);
      chk($sformatf("stall_data_%0d", i), WDATA, 32'hA5A50F0F);
    end
    wd = 0;
    for (int i = 0; i < 20 && wd == 0; i++) begin
      @(posedge ACLK); #1;
      if (wr_done) wd++;
    end
    chk("stall_done", wd, 32'd1);
    @(posedge ACLK); #1;
    chk("stall_mem", mem[16], 32'hA5A50F0F);
    aw_delay = 0; w_delay = 0;

    // Busy rejection: second strobe during W_RESP / W_DONE
    @(negedge ACLK); wr_start = 1'b1; wr_addr = 32'h060; wr_data = 32'h0BADF00D;
    @(posedge ACLK); #1; wr_start = 1'b0;
    @(posedge ACLK); #1;
    wr_start = 1'b1; wr_addr = 32'h020; wr_data = 32'hFFFFFFFF;
    chk("busy_in_resp", {wr_busy, BREADY}, 32'h3);
    wd = 0; av = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge ACLK); #1;
      if (wr_done) wd++;
      if (AWVALID) av++;
      if (i == 1) wr_start = 1'b0;
    end
    chk("busy_one_done", wd, 32'd1);
    chk("busy_no_new_aw", av, 32'd0);
    chk("busy_mem20", mem[8], 32'h0);
    chk("busy_mem60", mem[24], 32'h0BADF00D);

    // Concurrent write and read
    @(negedge ACLK);
    wr_start = 1'b1; wr_addr = 32'h030; wr_data = 32'h12345678;
    rd_start = 1'b1; rd_addr = 32'h010;
    @(posedge ACLK); #1; wr_start = 1'b0; rd_start = 1'b0;
    chk("conc_valids", {AWVALID, WVALID, ARVALID, RREADY}, 32'hF);
    wd = 0; rdn = 0; cap = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge ACLK); #1;
      if (wr_done) wd++;
      if (rd_done) begin rdn++; cap = rd_data; end
    end
    chk("conc_wr_done", wd, 32'd1);
    chk("conc_rd_done", rdn, 32'd1);
    chk("conc_rd_data", cap, 32'hDEADBEEF);
    chk("conc_mem30", mem[12], 32'h12345678);
    chk("conc_idle", {wr_busy, rd_busy}, 32'h0);

    // Reset during R_ADDR
    @(negedge ACLK); ar_delay = 20; rd_start = 1'b1; rd_addr = 32'h040;
    @(posedge ACLK); #1; rd_start = 1'b0;
    chk("rst_ar_up", {ARVALID, RREADY}, 32'h3);
    @(posedge ACLK); #3;
    ARESETN = 1'b0;
    #1;
    chk("rst_async", {ARVALID, RREADY, rd_busy, rd_done}, 32'h0);
    rdn = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge ACLK); #1;
      if (rd_done) rdn++;
    end
    @(negedge ACLK); ARESETN = 1'b1; ar_delay = 0;
    chk("rst_no_done", rdn, 32'd0);
    chk("rst_rd_data", rd_data, 32'h0);
    @(negedge ACLK); rd_start = 1'b1; rd_addr = 32'h040;
    @(posedge ACLK); #1; rd_start = 1'b0;
    rdn = 0; cap = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge ACLK); #1;
      if (rd_done) begin rdn++; cap = rd_data; end
    end
    chk("post_rst_done", rdn, 32'd1);
    chk("post_rst_data", cap, 32'hA5A50F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
